// File: rtl/alu_op_responder.sv
// alu_op_responder: handshaked ALU that queues results in order and returns them with the request tag.
module alu_op_responder #(
    parameter int N     = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [2:0]       in_f,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count,
    output logic             illegal_op
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = TAG_W + 3 + N;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic             illegal_q, illegal_d;
    logic             push, pop, sub, arith, ovf_raw;
    logic [N-1:0]     bb, y;
    logic [N:0]       sum;
    logic [EW-1:0]    entry, head;

    // one shared adder serves add, subtract and set-less-than
    always_comb begin
        sub     = in_f == 3'b110 || in_f == 3'b111;
        arith   = sub || in_f == 3'b010;
        bb      = sub ? ~in_b : in_b;
        sum     = {1'b0, in_a} + {1'b0, bb} + (N+1)'(sub);
        ovf_raw = (in_a[N-1] == bb[N-1]) && (sum[N-1] != in_a[N-1]);
        case (in_f)
            3'b000:         y = in_a & in_b;
            3'b001:         y = in_a | in_b;
            3'b010, 3'b110: y = sum[N-1:0];
            3'b100:         y = in_a & ~in_b;
            3'b101:         y = in_a | ~in_b;
            3'b111:         y = {{(N-1){1'b0}}, sum[N-1] ^ ovf_raw};
            default:        y = '0;
        endcase
        entry = {in_tag, y == '0, arith & ovf_raw, arith & sum[N], y};
    end

    assign in_ready  = reset && cnt_q < CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_q];
    assign {out_tag, out_zero, out_overflow, out_cout, out_y} = out_valid ? head : '0;
    assign op_count   = op_cnt_q;
    assign illegal_op = illegal_q;

    always_comb begin
        wr_d      = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d      = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d     = push && !pop ? cnt_q + 1'b1 : !push && pop ? cnt_q - 1'b1 : cnt_q;
        op_cnt_d  = pop ? op_cnt_q + 1'b1 : op_cnt_q;
        illegal_d = illegal_q || (push && in_f == 3'b011);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            op_cnt_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            op_cnt_q  <= op_cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // storage needs no reset: entries are only visible while counted valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= entry;
    end
endmodule
